pn_burst_ctrl: RTL and testbench

PN_BURST_CTRL -- requirements
Module: pn_burst_ctrl

---
 rtl/pn_ctrl_pkg.sv | 24 ++
 rtl/pn_lfsr5.sv | 35 +++
 rtl/pn_burst_ctrl.sv | 158 +++++++++++++++
 tb/tb_pn_burst_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pn_ctrl_pkg.sv
// Shared types and constants for the PN burst DAC controller.
// Holds the FSM states, the LFSR seed/taps and the chip period length.
package pn_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } pn_state_e;

  localparam logic [4:0] LFSR_SEED  = 5'b11111;
  localparam int         TAP_HI     = 4;
  localparam int         TAP_LO     = 2;
  localparam logic [4:0] PERIOD_LEN = 5'd31;
  localparam logic [4:0] LAST_CHIP  = PERIOD_LEN - 5'd1;

  // Shift left with feedback into bit 0; the MSB is the PN bit.
  function automatic logic [4:0] lfsr_next(input logic [4:0] s);
    return {s[3:0], s[TAP_HI] ^ s[TAP_LO]};
  endfunction

endpackage

// File: rtl/pn_lfsr5.sv
// 5-bit maximal-length LFSR; pn_bit is the MSB of the register.
// reseed has priority over step.
module pn_lfsr5
  import pn_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic step,
  input  logic reseed,
  output logic pn_bit
);

  logic [4:0] sr_q;
  logic [4:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (reseed) begin
      sr_d = LFSR_SEED;
    end else if (step) begin
      sr_d = lfsr_next(sr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr_q <= LFSR_SEED;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign pn_bit = sr_q[4];

endmodule

// File: rtl/pn_burst_ctrl.sv
// Drives a parallel DAC with a 31-chip PN sequence: LOAD, WRITE strobe, HOLD with LDAC.
// start is a level sampled only in IDLE; abort wins over everything while busy.
module pn_burst_ctrl
  import pn_ctrl_pkg::*;
#(
  parameter int CODE_W = 16,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DIV_W-1:0]  div,
  input  logic [7:0]        nper,
  input  logic [CODE_W-1:0] code_hi,
  input  logic [CODE_W-1:0] code_lo,
  output logic              busy,
  output logic              done,
  output logic [CODE_W-1:0] dac_data,
  output logic              dac_wr_n,
  output logic              dac_ldac_n,
  output logic [4:0]        chip_idx,
  output pn_state_e         dbg_state
);

  pn_state_e         state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [7:0]        nper_q, nper_d;
  logic [CODE_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [DIV_W-1:0]  hold_q, hold_d;
  logic [4:0]        chip_q, chip_d;
  logic [7:0]        per_q, per_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [CODE_W-1:0] data_q, data_d;
  logic              wr_n_q, wr_n_d, ldac_n_q, ldac_n_d;
  logic              lfsr_step, lfsr_reseed, pn_bit;
  logic [7:0]        per_inc;

  pn_lfsr5 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .step   (lfsr_step),
    .reseed (lfsr_reseed),
    .pn_bit (pn_bit)
  );

  assign per_inc = per_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    nper_d      = nper_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    hold_d      = hold_q;
    chip_d      = chip_q;
    per_d       = per_q;
    data_d      = data_q;
    wr_n_d      = 1'b1;
    ldac_n_d    = 1'b1;
    lfsr_step   = 1'b0;
    lfsr_reseed = 1'b0;

    // Abort leaves indices and dac_data as they were; only the strobes drop.
    if (abort && (state_q == ST_LOAD || state_q == ST_WRITE || state_q == ST_HOLD)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            div_d       = div;
            nper_d      = nper;
            hi_d        = code_hi;
            lo_d        = code_lo;
            chip_d      = 5'd0;
            per_d       = 8'd0;
            lfsr_reseed = 1'b1;
            state_d     = ST_LOAD;
          end
        end
        ST_LOAD: begin
          data_d  = pn_bit ? hi_q : lo_q;
          wr_n_d  = 1'b0;
          state_d = ST_WRITE;
        end
        ST_WRITE: begin
          hold_d   = div_q;
          ldac_n_d = 1'b0;
          state_d  = ST_HOLD;
        end
        ST_HOLD: begin
          if (hold_q != '0) begin
            hold_d = hold_q - DIV_W'(1);
          end else if (chip_q == LAST_CHIP) begin
            chip_d = 5'd0;
            per_d  = per_inc;
            if (nper_q != 8'd0 && per_inc == nper_q) begin
              state_d = ST_DONE;
            end else begin
              lfsr_step = 1'b1;
              state_d   = ST_LOAD;
            end
          end else begin
            chip_d    = chip_q + 5'd1;
            lfsr_step = 1'b1;
            state_d   = ST_LOAD;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_LOAD) || (state_d == ST_WRITE) || (state_d == ST_HOLD);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      nper_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hold_q   <= '0;
      chip_q   <= '0;
      per_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= '0;
      wr_n_q   <= 1'b1;
      ldac_n_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      nper_q   <= nper_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hold_q   <= hold_d;
      chip_q   <= chip_d;
      per_q    <= per_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      data_q   <= data_d;
      wr_n_q   <= wr_n_d;
      ldac_n_q <= ldac_n_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign dac_data   = data_q;
  assign dac_wr_n   = wr_n_q;
  assign dac_ldac_n = ldac_n_q;
  assign chip_idx   = chip_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pn_burst_ctrl.sv
// Scoreboard bench for pn_burst_ctrl: drivers queue expected strobes and done pulses,
// a negedge monitor pops and compares whenever the DUT strobes.
module tb_pn_burst_ctrl;
  import pn_ctrl_pkg::*;

  localparam int CODE_W = 16;
  localparam int DIV_W  = 16;
  localparam int EW     = 32 + 5 + CODE_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [DIV_W-1:0]  div = '0;
  logic [7:0]        nper = '0;
  logic [CODE_W-1:0] code_hi = '0;
  logic [CODE_W-1:0] code_lo = '0;
  logic              busy, done, dac_wr_n, dac_ldac_n;
  logic [CODE_W-1:0] dac_data;
  logic [4:0]        chip_idx;
  pn_state_e         dbg_state;

  pn_burst_ctrl #(.CODE_W(CODE_W), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .div        (div),
    .nper       (nper),
    .code_hi    (code_hi),
    .code_lo    (code_lo),
    .busy       (busy),
    .done       (done),
    .dac_data   (dac_data),
    .dac_wr_n   (dac_wr_n),
    .dac_ldac_n (dac_ldac_n),
    .chip_idx   (chip_idx),
    .dbg_state  (dbg_state)
  );

  // clock / reset / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference: the published chip sequence, chip 0 leftmost
  logic [30:0] pn_seq = 31'b1111100011011101010000100101100;

  logic [EW-1:0] exp_q[$];
  int            exp_done_q[$];
  int            checks = 0;
  int            failures = 0;
  int            n_strobes = 0;
  logic          prev_wr = 1'b0;
  logic [EW-1:0] mon_e;
  int            mon_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (!dac_wr_n) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL strobe_unexpected: got write chip %0d at cycle %0d expected none", chip_idx, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("strobe_cycle", 64'(cyc), 64'(mon_e[EW-1 -: 32]));
          chk("strobe_chip", 64'(chip_idx), 64'(mon_e[CODE_W +: 5]));
          chk("strobe_data", 64'(dac_data), 64'(mon_e[CODE_W-1:0]));
        end
        chk("busy_at_write", 64'(busy), 64'd1);
        n_strobes++;
      end
      if (!dac_ldac_n) begin
        chk("ldac_after_wr", 64'(prev_wr), 64'd1);
        chk("wr_ldac_excl", 64'(dac_wr_n), 64'd1);
      end
      if (prev_wr && busy) chk("ldac_follows_wr", 64'(dac_ldac_n), 64'd0);
      if (done) begin
        if (exp_done_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done_unexpected: got done at cycle %0d expected none", cyc);
        end else begin
          mon_d = exp_done_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(mon_d));
        end
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_all_strobes", 64'(exp_q.size()), 64'd0);
      end
      prev_wr = !dac_wr_n;
    end else begin
      prev_wr = 1'b0;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || done) && n < budget) begin
      tick();
      n++;
    end
    if (busy || done) begin
      checks++;
      failures++;
      $display("FAIL wait_idle: got busy=%0b done=%0b expected idle within %0d cycles", busy, done, budget);
    end
  endtask

  task automatic wait_strobes(input int target, input int budget);
    int n = 0;
    while (n_strobes < target && n < budget) begin
      tick();
      n++;
    end
    if (n_strobes < target) begin
      checks++;
      failures++;
      $display("FAIL wait_strobes: got %0d expected %0d within %0d cycles", n_strobes, target, budget);
    end
  endtask

  // Called at #1 after a posedge with the DUT idle.
  task automatic start_burst(input logic [DIV_W-1:0] d, input logic [7:0] np,
                             input logic [CODE_W-1:0] hi, input logic [CODE_W-1:0] lo,
                             input int nchips, input bit expect_done);
    int s;
    int p;
    s = cyc;
    p = int'(d) + 3;
    div = d; nper = np; code_hi = hi; code_lo = lo; start = 1'b1;
    for (int n = 0; n < nchips; n++) begin
      exp_q.push_back({32'(s + 2 + n * p), 5'(n % 31), pn_seq[30 - (n % 31)] ? hi : lo});
    end
    if (expect_done) exp_done_q.push_back(s + 1 + 31 * int'(np) * p);
    tick();
    start = 1'b0;
    div = DIV_W'($urandom);
    nper = 8'($urandom);
    code_hi = CODE_W'($urandom);
    code_lo = CODE_W'($urandom);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_wr_n"}, 64'(dac_wr_n), 64'd1);
    chk({tag, "_ldac_n"}, 64'(dac_ldac_n), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [DIV_W-1:0]  d;
    logic [CODE_W-1:0] hi, lo;

    // reset values
    repeat (3) tick();
    chk_quiet("reset");
    chk("reset_data", 64'(dac_data), 64'd0);
    chk("reset_chip", 64'(chip_idx), 64'd0);
    chk("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    rst = 1'b1;
    tick();

    // single period, div=0
    start_burst(16'd0, 8'd1, 16'hFFFF, 16'h0000, 31, 1'b1);
    wait_idle(200);
    tick();

    // two periods, div=4, with a start pulse mid-burst that must be ignored
    hi = CODE_W'($urandom); lo = CODE_W'($urandom);
    base = n_strobes;
    start_burst(16'd4, 8'd2, hi, lo, 62, 1'b1);
    wait_strobes(base + 10, 200);
    start = 1'b1; div = 16'd1; code_hi = ~hi;
    tick();
    start = 1'b0;
    wait_idle(600);
    chk("two_period_strobes", 64'(n_strobes - base), 64'd62);
    tick();

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("collide_busy", 64'(busy), 64'd0);
    tick();
    chk("collide_state", 64'(dbg_state), 64'(ST_IDLE));

    // abort in the HOLD of chip 5, then restart
    d = DIV_W'($urandom_range(0, 4)); hi = CODE_W'($urandom); lo = CODE_W'($urandom);
    base = n_strobes;
    start_burst(d, 8'd1, hi, lo, 6, 1'b0);
    wait_strobes(base + 6, 100);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_quiet("abort");
    chk("abort_data", 64'(dac_data), 64'(pn_seq[30 - 5] ? hi : lo));
    tick();
    start_burst(DIV_W'($urandom_range(0, 3)), 8'd1, CODE_W'($urandom), CODE_W'($urandom), 31, 1'b1);
    wait_idle(300);
    tick();

    // continuous mode for 100 chips, then abort
    d = DIV_W'($urandom_range(0, 3));
    base = n_strobes;
    start_burst(d, 8'd0, CODE_W'($urandom), CODE_W'($urandom), 100, 1'b0);
    wait_strobes(base + 100, 800);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_quiet("cont_abort");

    // reset while in WRITE, with start held during reset
    d = DIV_W'($urandom_range(0, 3));
    tick();
    base = n_strobes;
    start_burst(d, 8'd1, CODE_W'($urandom), CODE_W'($urandom), 31, 1'b1);
    wait_strobes(base + 2, 50);
    repeat (int'(d) + 2) tick();
    chk("pre_reset_in_write", 64'(dac_wr_n), 64'd0);
    rst = 1'b0; start = 1'b1;
    tick();
    chk_quiet("midrst");
    chk("midrst_data", 64'(dac_data), 64'd0);
    chk("midrst_chip", 64'(chip_idx), 64'd0);
    start = 1'b0; rst = 1'b1;
    exp_q.delete();
    exp_done_q.delete();
    tick();
    chk("midrst_stays_idle", 64'(busy), 64'd0);

    // randomized full bursts
    for (int t = 0; t < 4; t++) begin
      logic [7:0] np;
      np = 8'($urandom_range(1, 2));
      repeat ($urandom_range(0, 3)) tick();
      start_burst(DIV_W'($urandom_range(0, 6)), np, CODE_W'($urandom), CODE_W'($urandom),
                  31 * int'(np), 1'b1);
      wait_idle(700);
      tick();
    end

    repeat (3) tick();
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("done_q_drained", 64'(exp_done_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
